// File: rtl/snn_pkg.sv
// Shared SNN types: current/weight type, synapse FSM states, clamp limits.
// narrow(): 17-bit -> 16-bit, clamps when SYN_CURRENT_SATURATE_EN is defined.
package snn_pkg;

  typedef logic signed [15:0] cur_t;

  typedef enum logic [1:0] {
    IDLE,
    DECAY,
    DRAIN
  } state_t;

  localparam cur_t I_MAX = 16'sh7fff;
  localparam cur_t I_MIN = 16'sh8000;

  function automatic cur_t narrow(
    input logic signed [16:0] v
  );
`ifdef SYN_CURRENT_SATURATE_EN
    if (v > 17'sd32767) return I_MAX;
    else if (v < -17'sd32768) return I_MIN;
    else return v[15:0];
`else
    return v[15:0];
`endif
  endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// Spike weight FIFO: push/pop, full/empty/count, combinational head read.
// Ports: clk, reset, push, wdata, pop, rdata, full, empty, count.
module spike_event_fifo
  import snn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  cur_t                     wdata,
  input  logic                     pop,
  output cur_t                     rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE = 1;
  localparam logic [AW:0]   C_ONE = 1;
  localparam logic [AW:0]   C_MAX = (AW+1)'(DEPTH);

  cur_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == C_MAX);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + P_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + P_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/synapse_current_gen.sv
// Synaptic current: per step, decay I then add every queued spike weight.
// Ports: clk, reset, spike_valid/weight/ready, step, I, step_done,
// step_overrun. Macro SYN_CURRENT_SATURATE_EN clamps instead of wrapping.
module synapse_current_gen
  import snn_pkg::*;
#(
  parameter int TAU_SHIFT  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic spike_valid,
  input  cur_t spike_weight,
  output logic spike_ready,
  input  logic step,
  output cur_t I,
  output logic step_done,
  output logic step_overrun
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  state_t                 state;
  logic [CW-1:0]          drain_cnt;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  cur_t                   head;
  logic                   push;
  logic                   pop;
  logic signed [16:0]     wide;
  logic signed [16:0]     dec;
  logic signed [16:0]     acc;

  assign spike_ready = ~fifo_full;
  assign push = spike_valid & ~fifo_full;
  assign pop  = (state == DRAIN) && (drain_cnt != '0) && !fifo_empty;

  assign wide = {I[15], I};
  assign dec  = wide - (wide >>> TAU_SHIFT);
  assign acc  = wide + {head[15], head};

  spike_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (spike_weight),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      I            <= '0;
      drain_cnt    <= '0;
      step_done    <= 1'b0;
      step_overrun <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (step && state != IDLE) step_overrun <= 1'b1;
      unique case (1'b1)
        (state == IDLE): begin
          if (step) state <= DECAY;
        end
        (state == DECAY): begin
          I         <= narrow(dec);
          // Events arriving after this point wait for the next step.
          drain_cnt <= fifo_count;
          state     <= DRAIN;
        end
        (state == DRAIN): begin
          if (drain_cnt != '0) begin
            I         <= narrow(acc);
            drain_cnt <= drain_cnt - CNT_ONE;
          end else begin
            state     <= IDLE;
            step_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synapse_current_gen.sv
// Directed bench for synapse_current_gen (default and TAU_SHIFT=15).
// Vector table for step sequences plus hand-written corner sequences.
module tb_synapse_current_gen;
  import snn_pkg::*;

`ifdef SYN_CURRENT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic v1, v2, s1, s2;
  cur_t w1, w2;
  logic r1, r2, d1, d2, o1, o2;
  cur_t i1, i2;

  synapse_current_gen dut1 (
    .clk          (clk),
    .reset        (reset),
    .spike_valid  (v1),
    .spike_weight (w1),
    .spike_ready  (r1),
    .step         (s1),
    .I            (i1),
    .step_done    (d1),
    .step_overrun (o1)
  );

  synapse_current_gen #(
    .TAU_SHIFT (15)
  ) dut2 (
    .clk          (clk),
    .reset        (reset),
    .spike_valid  (v2),
    .spike_weight (w2),
    .spike_ready  (r2),
    .step         (s2),
    .I            (i2),
    .step_done    (d2),
    .step_overrun (o2)
  );

  int checks = 0;
  int errors = 0;
  int lat;
  int tr [0:20];

  typedef struct {
    int n;
    int w [4];
    int exp_i;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push(input int sel, input int w);
    @(negedge clk);
    if (sel == 0) begin
      v1 = 1'b1;
      w1 = cur_t'(w);
    end else begin
      v2 = 1'b1;
      w2 = cur_t'(w);
    end
    @(negedge clk);
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  // lat = edges after the step-sampling edge until step_done is seen.
  task automatic do_step(input int sel);
    bit seen;
    @(negedge clk);
    if (sel == 0) s1 = 1'b1;
    else s2 = 1'b1;
    @(posedge clk);
    #1;
    s1 = 1'b0;
    s2 = 1'b0;
    lat = -1;
    seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (!seen) begin
        @(posedge clk);
        #1;
        tr[k] = (sel == 0) ? int'(i1) : int'(i2);
        if ((sel == 0 && d1) || (sel == 1 && d2)) begin
          lat = k;
          seen = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int nd;
    bit gone;
    reset = 1'b1;
    v1 = 0; v2 = 0; s1 = 0; s2 = 0;
    w1 = '0; w2 = '0;

    tbl[0] = '{0, '{0, 0, 0, 0}, 0};
    tbl[1] = '{1, '{100, 0, 0, 0}, 100};
    tbl[2] = '{0, '{0, 0, 0, 0}, 88};
    tbl[3] = '{1, '{-177, 0, 0, 0}, -100};
    tbl[4] = '{0, '{0, 0, 0, 0}, -87};
    tbl[5] = '{3, '{10, 20, 30, 0}, -16};
    tbl[6] = '{2, '{1000, -3, 0, 0}, 983};
    tbl[7] = '{4, '{1, 1, 1, 1}, 865};

    #12;
    chk("rst_I", i1, 0);
    chk("rst_done", d1, 0);
    chk("rst_overrun", o1, 0);
    chk("rst_ready", r1, 1);
    @(negedge clk);
    reset = 1'b0;

    // single event
    push(0, 100);
    do_step(0);
    chk("single_decay_I", tr[1], 0);
    chk("single_pop_I", tr[2], 100);
    chk("single_lat", lat, 3);

    // vector table
    do_reset();
    for (int v = 0; v < 8; v++) begin
      for (int e = 0; e < tbl[v].n; e++) push(0, tbl[v].w[e]);
      do_step(0);
      chk($sformatf("vec%0d_lat", v), lat, 2 + tbl[v].n);
      chk($sformatf("vec%0d_I", v), i1, tbl[v].exp_i);
    end

    // backpressure
    do_reset();
    for (int e = 1; e <= 4; e++) push(0, e);
    @(negedge clk);
    chk("bp_full_ready", r1, 0);
    v1 = 1'b1;
    w1 = 16'sd7;
    repeat (2) @(negedge clk);
    v1 = 1'b0;
    s1 = 1'b1;
    @(posedge clk);
    #1;
    s1 = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_decay_ready", r1, 0);
    @(posedge clk);
    #1;
    chk("bp_pop_ready", r1, 1);
    gone = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!gone) begin
        @(posedge clk);
        #1;
        if (d1) gone = 1'b1;
      end
    end
    chk("bp_done_seen", gone, 1);
    chk("bp_I", i1, 10);
    do_step(0);
    chk("bp_held_dropped_I", i1, 9);
    chk("bp_held_dropped_lat", lat, 2);

    // overrun
    do_reset();
    push(0, 5);
    push(0, 6);
    @(negedge clk);
    s1 = 1'b1;
    @(posedge clk);
    #1;
    s1 = 1'b0;
    nd = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) s1 = 1'b1;
      if (k == 3) s1 = 1'b0;
      if (d1) nd++;
    end
    chk("ovr_done_count", nd, 1);
    chk("ovr_flag", o1, 1);
    chk("ovr_I", i1, 11);
    do_step(0);
    chk("ovr_sticky", o1, 1);
    chk("ovr_next_lat", lat, 2);

    // reset mid-drain
    push(0, 300);
    push(0, 400);
    push(0, 500);
    @(negedge clk);
    s1 = 1'b1;
    @(posedge clk);
    #1;
    s1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_I", i1, 0);
    chk("mid_rst_ready", r1, 1);
    chk("mid_rst_overrun", o1, 0);
    chk("mid_rst_done", d1, 0);
    @(negedge clk);
    reset = 1'b0;
    do_step(0);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_I", i1, 0);

    // large values, TAU_SHIFT=3
    do_reset();
    push(0, 32000);
    do_step(0);
    chk("big_load_I", i1, 32000);
    push(0, 500);
    push(0, 500);
    do_step(0);
    chk("big_decay_I", tr[1], 28000);
    chk("big_pop1_I", tr[2], 28500);
    chk("big_pop2_I", tr[3], 29000);
    push(0, 16000);
    push(0, 16000);
    do_step(0);
    chk("ovf_decay_I", tr[1], 25375);
    chk("ovf_pop1_I", tr[2], SAT ? 32767 : -24161);
    chk("ovf_pop2_I", tr[3], SAT ? 32767 : -8161);

    // TAU_SHIFT=15 instance
    push(1, 32700);
    do_step(1);
    chk("t15_load_I", i2, 32700);
    push(1, 500);
    do_step(1);
    chk("t15_decay_I", tr[1], 32700);
    chk("t15_sat_I", tr[2], SAT ? 32767 : -32336);
    chk("t15_lat", lat, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
